// File: rtl/alu_decode_stage.sv
// RV64I decode stage: instruction word -> ALU control word, registered through a
// 2-entry skid buffer with valid/ready on both sides and a synchronous flush.
module alu_decode_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [63:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [4:0]  out_alu_function,
   output logic [1:0]  out_sel_a,
   output logic [1:0]  out_sel_b,
   output logic [63:0] out_imm,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic        out_word_op,
   output logic        out_illegal
);

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  fn;
      logic [1:0]  sel_a;
      logic [1:0]  sel_b;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        word_op;
      logic        illegal;
   } dec_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP32   = 7'b0111011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic        alt_ok;
   logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        legal;
   dec_t        dec;

   assign opc    = in_inst[6:0];
   assign f3     = in_inst[14:12];
   assign f7     = in_inst[31:25];
   assign alt_ok = (f3 == 3'b000) || (f3 == 3'b101);

   assign imm_i = {{52{in_inst[31]}}, in_inst[31:20]};
   assign imm_s = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b = {{52{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
   assign imm_j = {{44{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

   // R-type ops carry no immediate, so imm stays zero for OP/OP-32.
   always_comb begin
      dec         = '0;
      legal       = 1'b1;
      dec.pc      = in_pc;
      dec.rs1     = in_inst[19:15];
      dec.rs2     = in_inst[24:20];
      dec.rd      = in_inst[11:7];
      case (opc)
         OPC_OP: begin
            dec.fn = {1'b0, alt_ok & in_inst[30], f3};
            legal  = (f7 == 7'b0000000) || (f7 == 7'b0100000 && alt_ok);
         end
         OPC_OP32: begin
            dec.fn      = {1'b1, alt_ok & in_inst[30], f3};
            dec.word_op = 1'b1;
            legal       = (alt_ok || f3 == 3'b001) &&
                          ((f7 == 7'b0000000) || (f7 == 7'b0100000 && alt_ok));
         end
         OPC_OPIMM: begin
            dec.fn    = {1'b0, (f3 == 3'b101) & in_inst[30], f3};
            dec.sel_b = 2'b01;
            dec.imm   = imm_i;
            if (f3 == 3'b001)
               legal = (in_inst[31:26] == 6'b000000);
            else if (f3 == 3'b101)
               legal = (in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000);
         end
         OPC_OPIMM32: begin
            dec.fn      = {1'b1, (f3 == 3'b101) & in_inst[30], f3};
            dec.sel_b   = 2'b01;
            dec.imm     = imm_i;
            dec.word_op = 1'b1;
            case (f3)
               3'b000:  legal = 1'b1;
               3'b001:  legal = (f7 == 7'b0000000);
               3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
               default: legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            dec.sel_a = 2'b10;
            dec.sel_b = 2'b01;
            dec.imm   = imm_u;
         end
         OPC_AUIPC: begin
            dec.sel_a = 2'b01;
            dec.sel_b = 2'b01;
            dec.imm   = imm_u;
         end
         OPC_LOAD: begin
            dec.sel_b = 2'b01;
            dec.imm   = imm_i;
         end
         OPC_STORE: begin
            dec.sel_b = 2'b01;
            dec.imm   = imm_s;
         end
         OPC_BRANCH: begin
            dec.imm = imm_b;
            case (f3[2:1])
               2'b00:   dec.fn = 5'b01000;
               2'b10:   dec.fn = 5'b00010;
               2'b11:   dec.fn = 5'b00011;
               default: legal  = 1'b0;
            endcase
         end
         OPC_JAL: begin
            dec.sel_a = 2'b01;
            dec.sel_b = 2'b10;
            dec.imm   = imm_j;
         end
         OPC_JALR: begin
            dec.sel_a = 2'b01;
            dec.sel_b = 2'b10;
            dec.imm   = imm_i;
            legal     = (f3 == 3'b000);
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec.fn      = '0;
         dec.sel_a   = '0;
         dec.sel_b   = '0;
         dec.imm     = '0;
         dec.word_op = 1'b0;
      end
      dec.illegal = !legal;
   end

   dec_t main_q, skid_q;
   logic main_valid, skid_valid;
   logic in_acc, main_free;

   assign in_ready  = !skid_valid;
   assign in_acc    = in_valid & in_ready;
   assign main_free = !main_valid | out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_free) begin
         // in_ready is low whenever skid holds data, so skid and input never race
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (in_acc) begin
            main_q     <= dec;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (in_acc) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign out_valid        = main_valid;
   assign out_pc           = main_q.pc;
   assign out_alu_function = main_q.fn;
   assign out_sel_a        = main_q.sel_a;
   assign out_sel_b        = main_q.sel_b;
   assign out_imm          = main_q.imm;
   assign out_rs1          = main_q.rs1;
   assign out_rs2          = main_q.rs2;
   assign out_rd           = main_q.rd;
   assign out_word_op      = main_q.word_op;
   assign out_illegal      = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vector table plus hand-written
// backpressure, flush and reset sequences.
module tb_alu_decode_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc, out_pc, out_imm;
   logic [4:0]  out_alu_function, out_rs1, out_rs2, out_rd;
   logic [1:0]  out_sel_a, out_sel_b;
   logic        out_word_op, out_illegal;

   int n_cmp = 0;
   int n_bad = 0;

   alu_decode_stage dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_alu_function(out_alu_function), .out_sel_a(out_sel_a), .out_sel_b(out_sel_b),
      .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_word_op(out_word_op), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] inst;
      logic [4:0]  fn;
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic [63:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic        w;
      logic        ill;
   } vec_t;

   vec_t vt[$];

   task automatic add(string nm, logic [31:0] inst, logic [4:0] fn, logic [1:0] sa,
                      logic [1:0] sb, logic [63:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                      logic [4:0] rd, logic w, logic ill);
      vec_t v;
      v.name = nm; v.inst = inst; v.fn = fn; v.sa = sa; v.sb = sb; v.imm = imm;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.w = w; v.ill = ill;
      vt.push_back(v);
   endtask

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] I_ADD = 32'h002081B3;

   initial begin
      //   name      inst          fn        sa     sb     imm                     rs1 rs2 rd  w  ill
      add("add",    32'h002081B3, 5'b00000, 2'b00, 2'b00, 64'h0,                   1,  2,  3,  0, 0);
      add("sraiw",  32'h4033529B, 5'b11101, 2'b00, 2'b01, 64'h403,                 6,  3,  5,  1, 0);
      add("beq",    32'hFE000EE3, 5'b01000, 2'b00, 2'b00, 64'hFFFFFFFFFFFFFFFC,    0,  0,  29, 0, 0);
      add("mul",    32'h022081B3, 5'b00000, 2'b00, 2'b00, 64'h0,                   1,  2,  3,  0, 1);
      add("sub",    32'h402081B3, 5'b01000, 2'b00, 2'b00, 64'h0,                   1,  2,  3,  0, 0);
      add("or_alt", 32'h4020E1B3, 5'b00000, 2'b00, 2'b00, 64'h0,                   1,  2,  3,  0, 1);
      add("lui",    32'h123452B7, 5'b00000, 2'b10, 2'b01, 64'h12345000,            8,  3,  5,  0, 0);
      add("lui_neg",32'h800002B7, 5'b00000, 2'b10, 2'b01, 64'hFFFFFFFF80000000,    0,  0,  5,  0, 0);
      add("addi_m1",32'hFFF00093, 5'b00000, 2'b00, 2'b01, 64'hFFFFFFFFFFFFFFFF,    0,  31, 1,  0, 0);
      add("jal",    32'h008000EF, 5'b00000, 2'b01, 2'b10, 64'h8,                   0,  8,  1,  0, 0);
      add("sw",     32'hFE20AE23, 5'b00000, 2'b00, 2'b01, 64'hFFFFFFFFFFFFFFFC,    1,  2,  28, 0, 0);
      add("bltu",   32'h0020E863, 5'b00011, 2'b00, 2'b00, 64'h10,                  1,  2,  16, 0, 0);
      add("br_f3_2",32'h0020A863, 5'b00000, 2'b00, 2'b00, 64'h0,                   1,  2,  16, 0, 1);
      add("slli33", 32'h02109093, 5'b00001, 2'b00, 2'b01, 64'h21,                  1,  1,  1,  0, 0);
      add("slliw33",32'h0210909B, 5'b00000, 2'b00, 2'b00, 64'h0,                   1,  1,  1,  0, 1);
      add("srai",   32'h4010D093, 5'b01101, 2'b00, 2'b01, 64'h401,                 1,  1,  1,  0, 0);
      add("subw",   32'h402081BB, 5'b11000, 2'b00, 2'b00, 64'h0,                   1,  2,  3,  1, 0);
      add("op32_f2",32'h0020A1BB, 5'b00000, 2'b00, 2'b00, 64'h0,                   1,  2,  3,  0, 1);
      add("auipc",  32'h00001097, 5'b00000, 2'b01, 2'b01, 64'h1000,                0,  0,  1,  0, 0);
      add("jalr",   32'h004100E7, 5'b00000, 2'b01, 2'b10, 64'h4,                   2,  4,  1,  0, 0);
      add("jalr_f1",32'h004110E7, 5'b00000, 2'b00, 2'b00, 64'h0,                   2,  4,  1,  0, 1);
      add("bad_opc",32'h0000007F, 5'b00000, 2'b00, 2'b00, 64'h0,                   0,  0,  0,  0, 1);

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = '0; in_pc = '0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready, 1);
      chk("rst_pc",        out_pc, 0);
      chk("rst_imm",       out_imm, 0);
      chk("rst_fn",        out_alu_function, 0);
      @(negedge clk) reset = 1'b0;
      tick();

      // back-to-back decode at full throughput
      out_ready = 1'b1;
      for (int i = 0; i < vt.size(); i++) begin
         in_valid = 1'b1;
         in_inst  = vt[i].inst;
         in_pc    = 64'h1000 + 64'(i * 4);
         tick();
         chk({vt[i].name, ".valid"}, out_valid, 1);
         chk({vt[i].name, ".pc"},    out_pc, 64'h1000 + 64'(i * 4));
         chk({vt[i].name, ".fn"},    out_alu_function, vt[i].fn);
         chk({vt[i].name, ".sel_a"}, out_sel_a, vt[i].sa);
         chk({vt[i].name, ".sel_b"}, out_sel_b, vt[i].sb);
         chk({vt[i].name, ".imm"},   out_imm, vt[i].imm);
         chk({vt[i].name, ".rs1"},   out_rs1, vt[i].rs1);
         chk({vt[i].name, ".rs2"},   out_rs2, vt[i].rs2);
         chk({vt[i].name, ".rd"},    out_rd, vt[i].rd);
         chk({vt[i].name, ".word"},  out_word_op, vt[i].w);
         chk({vt[i].name, ".ill"},   out_illegal, vt[i].ill);
         chk({vt[i].name, ".in_rdy"}, in_ready, 1);
      end
      in_valid = 1'b0;
      tick();
      chk("drain_valid", out_valid, 0);

      // backpressure: two accepts fill the buffer, then drain in order
      out_ready = 1'b0; in_valid = 1'b1; in_inst = I_ADD; in_pc = 64'h0;
      tick();
      chk("bp_rdy_after1", in_ready, 1);
      chk("bp_pc0_first",  out_pc, 64'h0);
      in_pc = 64'h4;
      tick();
      chk("bp_rdy_after2", in_ready, 0);
      chk("bp_valid_stall", out_valid, 1);
      chk("bp_pc0_hold1",  out_pc, 64'h0);
      in_pc = 64'h8;
      tick();
      chk("bp_rdy_full",   in_ready, 0);
      chk("bp_pc0_hold2",  out_pc, 64'h0);
      chk("bp_fn_hold",    out_alu_function, 5'b00000);
      chk("bp_rd_hold",    out_rd, 5'd3);
      out_ready = 1'b1;
      tick();
      chk("bp_v4",  out_valid, 1);
      chk("bp_pc4", out_pc, 64'h4);
      chk("bp_rdy_reopen", in_ready, 1);
      tick();
      chk("bp_v8",  out_valid, 1);
      chk("bp_pc8", out_pc, 64'h8);
      in_pc = 64'hC;
      tick();
      chk("bp_vC",  out_valid, 1);
      chk("bp_pcC", out_pc, 64'hC);
      in_valid = 1'b0;
      tick();
      chk("bp_end_valid", out_valid, 0);

      // flush with both entries full
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h40;
      tick();
      in_pc = 64'h44;
      tick();
      chk("fl_full_rdy", in_ready, 0);
      flush = 1'b1; in_pc = 64'h48;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", out_valid, 0);
      chk("fl_rdy",   in_ready, 1);
      tick();
      chk("fl_stay_empty", out_valid, 0);

      // input offered during flush is dropped
      out_ready = 1'b1; in_valid = 1'b1; in_pc = 64'h50; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_drop_valid", out_valid, 0);
      tick();
      chk("fl_drop_valid2", out_valid, 0);

      // asynchronous reset mid-stream
      out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h60;
      tick();
      chk("ar_pre_valid", out_valid, 1);
      in_pc = 64'h64;
      #2 reset = 1'b1;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_rdy",   in_ready, 1);
      chk("ar_pc",    out_pc, 0);
      @(negedge clk);
      reset = 1'b0; in_valid = 1'b0;
      tick();
      chk("ar_post_valid", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
